dmem_byte_ctrl: RTL
===================

# dmem_byte_ctrl

Parametrised, handshaked data memory for the RISC-V datapath. It supports byte, halfword and word loads and stores, selected by the instruction's funct3, and returns little-endian sign- or zero-extended load data. A programmable wait-state counter lets it model slow memory for the multicycle/pipelined core. It replaces the fixed word-only single-cycle data memory behind the load/store path.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 4..65536.
- ADDR_W, 32, byte-address width.
- WAIT_CYCLES, 1, extra cycles inserted before the array access; 0..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- WE  in  1  1 = store, 0 = load; sampled at accept.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; sampled at accept.
- A  in  ADDR_W  byte address; sampled at accept.
- WD  in  32  store data; low bits used for B/H; sampled at accept.
- resp_valid  out  1  one-cycle pulse; RD/err valid.
- RD  out  32  extended load data; 0 for stores and errors.
- err  out  1  request faulted; meaningful with resp_valid.

## Operation
- Handshake: accept when req_valid && req_ready. A, WD, WE and funct3 are latched at accept. Inputs are ignored at all other times.
- FSM states:
  - IDLE: req_ready=1. On accept, go to WAIT (WAIT_CYCLES>0) or ACCESS (WAIT_CYCLES=0).
  - WAIT: a 4-bit counter loads WAIT_CYCLES-1 at accept and decrements each cycle. When it reaches 0, go to ACCESS.
  - ACCESS: the array is read or written. Go to RESP.
  - RESP: resp_valid=1, RD/err driven. Go to IDLE.
- Word index = A[log2(DEPTH_WORDS)+1:2]. Byte lane = A[1:0]. Little-endian lanes: byte 0 = bits 7:0.
- Stores write byte enables only:
  - SB writes lane A[1:0].
  - SH writes lanes A[1]*2 and +1.
  - SW writes all 4 lanes.
  - Other bytes are unchanged.
- Loads:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW returns the word.
- Faults (err=1, RD=0, no array write):
  - illegal funct3 (011, 110, 111, or 1xx with WE=1);
  - address bits above the index range nonzero;
  - misalignment (see Configuration).
- Memory contents are not affected by rst.

## Timing
- Accept at edge T. resp_valid is high in cycle T+WAIT_CYCLES+2 for exactly one cycle.
- Throughput: one request per WAIT_CYCLES+3 cycles. req_ready is 0 from the cycle after accept until IDLE is re-entered.
- Store data is visible to a subsequent load (read-after-write). No bypass is needed because accesses are serialised.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, RD=0, err=0, wait counter=0.
- rst has priority over every state. Reset asserted during ACCESS suppresses the write. An abandoned request produces no resp_valid.
- req_valid held high during RESP is not accepted until the following IDLE cycle.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - H access with A[0]=1 or W access with A[1:0]≠0 faults: err=1, no write, RD=0.
- Undefined:
  - A is forced to natural alignment (A[0] cleared for H, A[1:0] cleared for W) and the access proceeds; err reflects only the funct3 and range faults.

## Structure
- Package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum IDLE/WAIT/ACCESS/RESP;
  - the byte-enable width constant.
- Sub-module dmem_lane_align (combinational) holds:
  - byte-enable and shifted write-data generation from funct3 and A[1:0];
  - load extraction and extension from the read word.
- The top level holds the FSM, wait counter, request latches and the array.

## Test plan
- WAIT_CYCLES=1: SW A=0x4 WD=0x80FF7F01, then LW A=0x4 -> RD=0x80FF7F01, err=0; resp_valid 3 cycles after each accept.
- After the above, LB A=0x7 -> 0xFFFFFF80; LBU A=0x7 -> 0x00000080; LH A=0x4 -> 0x00007F01; LHU A=0x6 -> 0x000080FF.
- SB A=0x5 WD=0x000000AA on word 0x80FF7F01, then LW A=0x4 -> 0x80FFAA01 (other lanes untouched).
- LW A=0x6 with DMEM_MISALIGN_TRAP_EN -> err=1, RD=0. Without the macro -> RD=word at 0x4, err=0. SW A=0x400 with DEPTH_WORDS=256 -> err=1, array unchanged.
- SW accepted, rst asserted for one cycle during ACCESS, then LW same address -> old value, no resp_valid for the aborted store; outputs 0 and req_ready=1 after reset.
- WAIT_CYCLES=0 and 15: back-to-back req_valid held high -> accepts spaced 3 and 18 cycles apart; funct3=011 -> err=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and funct3 legality helper for the byte-addressable data memory.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    // Stores only have signed encodings; the unsigned ones are load-only.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load extraction with
// sign or zero extension. Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [31:0]     wd,
    input  logic [31:0]     rword,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata,
    output logic [31:0]     rd_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword[8*off +: 8];
    assign rhalf = off[1] ? rword[31:16] : rword[15:0];

    // Write data is replicated across lanes so the enables alone pick the target bytes.
    always_comb begin
        be    = '0;
        wdata = wd;
        case (funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << off;
                wdata = {4{wd[7:0]}};
            end
            F3_H, F3_HU: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wd[15:0]}};
            end
            F3_W:    be = 4'b1111;
            default: be = '0;
        endcase
    end

    always_comb begin
        rd_ext = '0;
        case (funct3)
            F3_B:    rd_ext = {{24{rbyte[7]}}, rbyte};
            F3_BU:   rd_ext = {24'd0, rbyte};
            F3_H:    rd_ext = {{16{rhalf[15]}}, rhalf};
            F3_HU:   rd_ext = {16'd0, rhalf};
            F3_W:    rd_ext = rword;
            default: rd_ext = '0;
        endcase
    end

endmodule

// File: rtl/dmem_byte_ctrl.sv
// Handshaked B/H/W data memory with programmable wait states.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of force-aligning them.
module dmem_byte_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              WE,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       WD,
    output logic              resp_valid,
    output logic [31:0]       RD,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wd_q, wd_d;

    logic              f3_bad, range_bad, mis_bad, fault, wr_en;
    logic              is_h, is_w;
    logic [1:0]        off_eff;
    logic [IDX_W-1:0]  idx;
    logic [BE_W-1:0]   be;
    logic [31:0]       wdata, rword, rd_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d   = WE;
                    f3_d   = funct3;
                    addr_d = A;
                    wd_d   = WD;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    assign is_h   = (f3_q[1:0] == 2'b01);
    assign is_w   = (f3_q == F3_W);
    assign f3_bad = !f3_legal(f3_q, we_q);
    assign idx    = addr_q[IDX_W+1:2];

    generate
        if (ADDR_W > IDX_W + 2) begin : g_range
            assign range_bad = |addr_q[ADDR_W-1:IDX_W+2];
        end else begin : g_norange
            assign range_bad = 1'b0;
        end
    endgenerate

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis_bad = (is_h && addr_q[0]) || (is_w && (addr_q[1:0] != 2'b00));
    assign off_eff = addr_q[1:0];
`else
    assign mis_bad = 1'b0;
    assign off_eff = is_w ? 2'b00 : (is_h ? {addr_q[1], 1'b0} : addr_q[1:0]);
`endif

    assign fault = f3_bad || range_bad || mis_bad;
    // Reset seen in ACCESS must cancel the write landing on that same edge.
    assign wr_en = we_q && !fault && !rst;

    dmem_lane_align u_lane (
        .funct3 (f3_q),
        .off    (off_eff),
        .wd     (wd_q),
        .rword  (rword),
        .be     (be),
        .wdata  (wdata),
        .rd_ext (rd_ext)
    );

    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rdata_lane_q;
            always_ff @(posedge clk) begin
                if (state_q == ACCESS) begin
                    if (wr_en && be[gi]) mem[idx] <= wdata[8*gi +: 8];
                    rdata_lane_q <= mem[idx];
                end
            end
            assign rword[8*gi +: 8] = rdata_lane_q;
        end
    endgenerate

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        err        = 1'b0;
        RD         = '0;
        if (state_q == RESP) begin
            err = fault;
            if (!we_q && !fault) RD = rd_ext;
        end
    end

endmodule
